// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage load/store controller on a single-outstanding req/ack bus; MEM_TIMEOUT_EN adds an ack timeout.
module mem_access_ctrl #(
  parameter int WORD = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_valid_in,
  input  logic            mem_we_in,
  input  logic [1:0]      mem_size_in,
  input  logic            mem_sign_in,
  input  logic [WORD-1:0] addr_in,
  input  logic [WORD-1:0] wdata_in,
  output logic            stall_out,
  output logic [WORD-1:0] rdata_out,
  output logic            rdata_valid_out,
  output logic            misalign_out,
  output logic            bus_err_out,
  output logic            bus_req,
  output logic            bus_we,
  output logic [WORD-1:0] bus_addr,
  output logic [3:0]      bus_wstrb,
  output logic [WORD-1:0] bus_wdata,
  input  logic            bus_ack,
  input  logic [WORD-1:0] bus_rdata
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t state;
  logic [1:0] a, a_q, sz_q;
  logic sg_q, aligned, start, tmo;
  logic [3:0] strb;
  logic [WORD-1:0] wd, sh, ext;
  assign a = addr_in[1:0];
  assign aligned = mem_size_in == 2'b00 ? 1'b1 : mem_size_in == 2'b01 ? !a[0] : a == 2'b00;
  assign start = mem_valid_in & aligned & (state == IDLE);
  assign stall_out = start | (state == REQ);
  always_comb begin
    strb = !mem_we_in ? 4'b0000 : mem_size_in == 2'b00 ? 4'b0001 << a :
           mem_size_in == 2'b01 ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wd = mem_size_in == 2'b00 ? {4{wdata_in[7:0]}} :
         mem_size_in == 2'b01 ? {2{wdata_in[15:0]}} : wdata_in;
    sh = bus_rdata >> {a_q, 3'b000};
    ext = sz_q == 2'b00 ? {{(WORD-8){sg_q & sh[7]}}, sh[7:0]} :
          sz_q == 2'b01 ? {{(WORD-16){sg_q & sh[15]}}, sh[15:0]} : sh;
  end
`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1) < 8 ? 8 : $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  assign tmo = cnt == CW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else cnt <= state == REQ ? cnt + 1'b1 : '0;
`else
  assign tmo = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_q <= '0;
      sz_q <= '0;
      sg_q <= 1'b0;
      rdata_out <= '0;
      rdata_valid_out <= 1'b0;
      misalign_out <= 1'b0;
      bus_err_out <= 1'b0;
      bus_req <= 1'b0;
      bus_we <= 1'b0;
      bus_addr <= '0;
      bus_wstrb <= '0;
      bus_wdata <= '0;
    end else begin
      rdata_valid_out <= 1'b0;
      misalign_out <= 1'b0;
      bus_err_out <= 1'b0;
      case (state)
        IDLE: begin
          misalign_out <= mem_valid_in & !aligned;
          if (start) begin
            state <= REQ;
            a_q <= a;
            sz_q <= mem_size_in;
            sg_q <= mem_sign_in;
            bus_req <= 1'b1;
            bus_we <= mem_we_in;
            bus_addr <= {addr_in[WORD-1:2], 2'b00};
            bus_wstrb <= strb;
            bus_wdata <= wd;
          end
        end
        REQ:
          if (bus_ack | tmo) begin
            state <= DONE;
            bus_req <= 1'b0;
            rdata_valid_out <= 1'b1;
            bus_err_out <= !bus_ack;
            rdata_out <= bus_ack & !bus_we ? ext : '0;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: scoreboard bench for mem_access_ctrl; expected load results queue up at issue and retire on rdata_valid_out.
module tb_mem_access_ctrl;
  logic clk = 0, rst = 1;
  logic mem_valid_in = 0, mem_we_in = 0, mem_sign_in = 0, bus_ack = 0;
  logic [1:0] mem_size_in = 0;
  logic [31:0] addr_in = 0, wdata_in = 0, bus_rdata = 0;
  logic stall_out, rdata_valid_out, misalign_out, bus_err_out, bus_req, bus_we;
  logic [31:0] rdata_out, bus_addr, bus_wdata;
  logic [3:0] bus_wstrb;
  int n_checks = 0, n_fail = 0;
  logic [31:0] sb[$];

  mem_access_ctrl #(.WORD(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .mem_valid_in(mem_valid_in), .mem_we_in(mem_we_in),
    .mem_size_in(mem_size_in), .mem_sign_in(mem_sign_in), .addr_in(addr_in),
    .wdata_in(wdata_in), .stall_out(stall_out), .rdata_out(rdata_out),
    .rdata_valid_out(rdata_valid_out), .misalign_out(misalign_out),
    .bus_err_out(bus_err_out), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk)
    if (!rst && rdata_valid_out) begin
      if (sb.size() == 0) check("unexpected_valid", 1, 0);
      else check("rdata", rdata_out, sb.pop_front());
    end

  task automatic issue(input logic we, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                       input logic [31:0] wd);
    @(negedge clk);
    mem_valid_in = 1; mem_we_in = we; mem_size_in = sz; mem_sign_in = sg;
    addr_in = a; wdata_in = wd;
    #1 check("stall_start", stall_out, 1);
  endtask

  task automatic access(input logic we, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd, input int dly,
                        input logic [31:0] exp_rd, input logic [3:0] exp_strb, input logic [31:0] exp_wd);
    issue(we, sz, sg, a, wd);
    sb.push_back(exp_rd);
    bus_rdata = ~rd;
    @(posedge clk);
    for (int i = 0; i <= dly; i++) begin
      @(negedge clk);
      check("bus_req", bus_req, 1);
      check("stall_req", stall_out, 1);
      check("bus_addr", bus_addr, a & 32'hFFFF_FFFC);
      check("bus_we", bus_we, we);
      check("bus_wstrb", bus_wstrb, exp_strb);
      if (we) check("bus_wdata", bus_wdata, exp_wd);
      if (i == dly) begin bus_ack = 1; bus_rdata = rd; end
    end
    @(posedge clk);
    @(negedge clk);
    bus_ack = 0; bus_rdata = 0;
    check("valid_pulse", rdata_valid_out, 1);
    check("stall_done", stall_out, 0);
    check("req_done", bus_req, 0);
    mem_valid_in = 0;
    @(negedge clk);
    check("valid_end", rdata_valid_out, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req", bus_req, 0);
    check("rst_rdata", rdata_out, 0);
    check("rst_valid", rdata_valid_out, 0);
    check("rst_addr", bus_addr, 0);
    check("rst_strb", bus_wstrb, 0);
    check("rst_stall", stall_out, 0);
    rst = 0;
    access(0, 2'b10, 0, 32'h1000, 0, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 4'b0000, 0);
    access(0, 2'b00, 1, 32'h1003, 0, 32'h8012_3456, 1, 32'hFFFF_FF80, 4'b0000, 0);
    access(0, 2'b00, 0, 32'h1003, 0, 32'h8012_3456, 0, 32'h0000_0080, 4'b0000, 0);
    access(1, 2'b01, 0, 32'h2002, 32'h0000_ABCD, 32'h5555_5555, 3, 0, 4'b1100, 32'hABCD_ABCD);
    access(0, 2'b01, 1, 32'h2002, 0, 32'h8001_1234, 0, 32'hFFFF_8001, 4'b0000, 0);
    access(0, 2'b01, 0, 32'h2000, 0, 32'h1234_F00D, 2, 32'h0000_F00D, 4'b0000, 0);
    access(0, 2'b00, 1, 32'h2001, 0, 32'h0000_7F00, 0, 32'h0000_007F, 4'b0000, 0);
    access(1, 2'b00, 0, 32'h3001, 32'h1234_5677, 0, 0, 0, 4'b0010, 32'h7777_7777);
    access(1, 2'b10, 0, 32'h4000, 32'h1122_3344, 0, 1, 0, 4'b1111, 32'h1122_3344);
    access(0, 2'b11, 0, 32'h4004, 0, 32'hCAFE_F00D, 0, 32'hCAFE_F00D, 4'b0000, 0);
    // misaligned word: one misalign pulse, no bus request, no stall
    @(negedge clk);
    mem_valid_in = 1; mem_we_in = 0; mem_size_in = 2'b10; addr_in = 32'h1001;
    #1 check("mis_stall", stall_out, 0);
    @(negedge clk);
    check("mis_pulse", misalign_out, 1);
    check("mis_req", bus_req, 0);
    mem_valid_in = 0;
    @(negedge clk);
    check("mis_end", misalign_out, 0);
    check("mis_req2", bus_req, 0);
    // stray ack in IDLE does nothing
    bus_ack = 1; bus_rdata = 32'h1111_2222;
    repeat (2) @(negedge clk);
    check("idle_ack_req", bus_req, 0);
    check("idle_ack_valid", rdata_valid_out, 0);
    bus_ack = 0;
    // reset mid-access; late ack ignored
    issue(0, 2'b10, 0, 32'h5000, 0);
    @(negedge clk);
    check("pre_rst_req", bus_req, 1);
    rst = 1; mem_valid_in = 0;
    @(negedge clk);
    check("rst_mid_req", bus_req, 0);
    rst = 0; bus_ack = 1; bus_rdata = 32'hBAD0_BAD0;
    #1 check("rst_mid_stall", stall_out, 0);
    @(negedge clk);
    bus_ack = 0;
    check("rst_mid_valid", rdata_valid_out, 0);
    check("rst_mid_req2", bus_req, 0);
    check("rst_mid_rdata", rdata_out, 0);
`ifdef MEM_TIMEOUT_EN
    issue(0, 2'b10, 0, 32'h6000, 0);
    sb.push_back(0);
    bus_rdata = 32'hFFFF_FFFF;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("tmo_req", bus_req, 1);
      check("tmo_err_early", bus_err_out, 0);
    end
    @(negedge clk);
    check("tmo_err", bus_err_out, 1);
    check("tmo_valid", rdata_valid_out, 1);
    check("tmo_stall", stall_out, 0);
    check("tmo_req_drop", bus_req, 0);
    mem_valid_in = 0;
    @(negedge clk);
    check("tmo_err_end", bus_err_out, 0);
`else
    check("no_err", bus_err_out, 0);
`endif
    repeat (2) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- MEM-stage data-memory access controller; it is the producer of the DCache stall consumed by the EX/MEM pipeline register.
- Takes the load/store request held in EX/MEM and drives a single-outstanding req/ack memory bus.
- Holds the pipeline with a combinational stall until the access completes.
- Returns byte/half/word load data, aligned and sign- or zero-extended, for writeback.

Parameters:
- WORD, 32, data/address width.
- TIMEOUT_CYCLES, 255, ack wait limit in cycles; used only when MEM_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- mem_valid_in  in  1  EX/MEM holds a load/store this cycle
- mem_we_in  in  1  1=store, 0=load
- mem_size_in  in  2  00 byte, 01 half, 10 word, 11 treated as word
- mem_sign_in  in  1  load sign-extend when 1, zero-extend when 0
- addr_in  in  WORD  byte address (ALU result)
- wdata_in  in  WORD  store data, right-aligned
- stall_out  out  1  to the EX/MEM register stall input; combinational
- rdata_out  out  WORD  aligned/extended load result
- rdata_valid_out  out  1  one-cycle pulse: access completed
- misalign_out  out  1  one-cycle pulse: misaligned request rejected
- bus_err_out  out  1  one-cycle pulse: timeout abort
- bus_req  out  1  bus request, registered
- bus_we  out  1  bus write enable
- bus_addr  out  WORD  word-aligned address (low 2 bits forced to 0)
- bus_wstrb  out  4  byte write strobes, 0000 for loads
- bus_wdata  out  WORD  lane-replicated store data
- bus_ack  in  1  bus completion
- bus_rdata  in  WORD  read data, valid with bus_ack

Behaviour:
- Reset values: state IDLE; all outputs 0, including rdata_out and the bus outputs.
- Reset mid-access drops bus_req on the next edge; a stale bus_ack after that is ignored.
- FSM states: IDLE, REQ, DONE.
- Definitions:
  - start = mem_valid_in & aligned & state==IDLE.
  - aligned = byte, or half with addr[0]==0, or word with addr[1:0]==00.
- IDLE:
  - On start, latch addr, we, size, sign and wdata; go to REQ.
  - If mem_valid_in & !aligned: pulse misalign_out next cycle, stay IDLE, no bus activity, no stall.
- REQ:
  - bus_req=1; bus_addr, bus_we, bus_wstrb and bus_wdata stay stable until bus_ack.
  - On bus_ack: capture bus_rdata, drop bus_req, go to DONE.
- DONE:
  - rdata_valid_out=1 for exactly one cycle; rdata_out holds until the next completion.
  - Always go to IDLE; never starts a new access, so the held instruction cannot re-trigger.
- stall_out = start | (state==REQ); it is low in DONE, which releases EX/MEM on that edge.
- Minimum latency with ack on the first REQ cycle: stall high 2 cycles (the start cycle plus the REQ cycle), rdata_valid_out on the 3rd.
- Store lanes, with a = addr[1:0]:
  - Byte: bus_wstrb = 0001<<a; wdata[7:0] replicated into all 4 lanes.
  - Half: bus_wstrb = a[1] ? 1100 : 0011; wdata[15:0] replicated into both halves.
  - Word: bus_wstrb = 1111; wdata passed through.
- Load extract: bus_rdata >> (8*a), then take 8/16/32 bits and extend per the latched sign.
- Stores also pulse rdata_valid_out; rdata_out is 0 for stores.
- bus_ack while not in REQ is ignored.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined:
  - An 8+-bit counter runs in REQ.
  - After TIMEOUT_CYCLES cycles without ack: drop bus_req, pulse bus_err_out, go to DONE with rdata_out=0 and rdata_valid_out=1.
  - An ack in the same cycle as the timeout wins.
- Undefined: REQ waits indefinitely; bus_err_out tied to 0; no counter logic.

Test Plan:
- Load word, addr 0x1000, bus_rdata 0xDEADBEEF, ack 1 cycle after req -> stall high 2 cycles, bus_addr 0x1000, wstrb 0000, then rdata_out 0xDEADBEEF with a 1-cycle valid pulse.
- Load byte signed, addr 0x1003, bus_rdata 0x80123456 -> rdata_out 0xFFFFFF80; same access unsigned -> 0x00000080.
- Store half, addr 0x2002, wdata 0x0000ABCD -> bus_wstrb 1100, bus_wdata 0xABCDABCD, bus_we 1; bus_req held through 3 cycles of ack delay, stall high throughout.
- Load word at addr 0x1001 -> misalign_out pulse, bus_req stays 0, stall_out 0.
- rst asserted while in REQ, then bus_ack arrives -> bus_req 0 after the edge, state IDLE, no rdata_valid_out.
- MEM_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, ack never arrives -> bus_err_out pulse after 4 REQ cycles, stall released, rdata_out 0.
